// File: rtl/passcode_pkg.sv
// Shared definitions for the keypad passcode checker.
//   state_t     : FSM state encoding
//   *_DEF       : default parameter values
//   cnt_w()     : width helper for counters holding 0..n-1
//   max_int()   : larger of two integers
package passcode_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        CHECK   = 3'd2,
        PASS    = 3'd3,
        FAIL    = 3'd4,
        LOCKOUT = 3'd5
    } state_t;

    localparam int CODE_LEN_DEF       = 4;
    localparam int DIGIT_W_DEF        = 4;
    localparam int MAX_FAIL_DEF       = 3;
    localparam int LOCK_CYCLES_DEF    = 100;
    localparam int TIMEOUT_CYCLES_DEF = 50;
    localparam int PASS_HOLD_DEF      = 2;

    // Bits needed to hold values 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/passcode_checker_if.sv
// Keypad/gate signal bundle for the passcode checker.
//   master : drives car_in, digit_valid, digit, code_word; observes results
//   slave  : the checker; consumes keypad inputs, drives pass_ok, pass_fail,
//            locked, busy
interface passcode_checker_if
    import passcode_pkg::*;
#(
    parameter int CODE_LEN = CODE_LEN_DEF,
    parameter int DIGIT_W  = DIGIT_W_DEF
);
    logic                          car_in;
    logic                          digit_valid;
    logic [DIGIT_W-1:0]            digit;
    logic [CODE_LEN*DIGIT_W-1:0]   code_word;
    logic                          pass_ok;
    logic                          pass_fail;
    logic                          locked;
    logic                          busy;

    modport master (
        output car_in, digit_valid, digit, code_word,
        input  pass_ok, pass_fail, locked, busy
    );

    modport slave (
        input  car_in, digit_valid, digit, code_word,
        output pass_ok, pass_fail, locked, busy
    );
endinterface

// File: rtl/passcode_timer.sv
// Loadable down-counter with a done flag.
//   clk, reset_n : clock, async active-low reset
//   load         : load load_val (takes priority over en)
//   load_val     : value to load; counter then needs load_val further enabled
//                  cycles to reach zero
//   en           : decrement by one, stopping at zero
//   done         : counter is zero
module passcode_timer
    import passcode_pkg::*;
#(
    parameter int MAX_VAL = 100,
    parameter int W       = cnt_w(MAX_VAL)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);
    logic [W-1:0] count_r;

    // Down-counter; holds at zero rather than wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != {W{1'b0}})) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == {W{1'b0}});
endmodule

// File: rtl/passcode_checker.sv
// Keypad passcode checker feeding pass_ok to the parking FSM.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : car_in, digit_valid, digit, code_word in;
//                  pass_ok, pass_fail, locked, busy out (registered)
// A car_in rising edge arms entry of CODE_LEN digits; the whole code is
// always collected before judging so a wrong digit is not revealed early.
module passcode_checker
    import passcode_pkg::*;
#(
    parameter int CODE_LEN       = CODE_LEN_DEF,
    parameter int DIGIT_W        = DIGIT_W_DEF,
    parameter int MAX_FAIL       = MAX_FAIL_DEF,
    parameter int LOCK_CYCLES    = LOCK_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int PASS_HOLD      = PASS_HOLD_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    passcode_checker_if.slave  bus
);
    localparam int IDX_W    = cnt_w(CODE_LEN);
    localparam int FAIL_W   = cnt_w(MAX_FAIL + 1);
    localparam int TO_W     = cnt_w(TIMEOUT_CYCLES);
    localparam int HOLD_MAX = max_int(PASS_HOLD, LOCK_CYCLES);
    localparam int HD_W     = cnt_w(HOLD_MAX);

    state_t              state_r, state_s;
    logic [IDX_W-1:0]    idx_r, idx_s;
    logic                mismatch_r, mismatch_s;
    logic [FAIL_W-1:0]   fail_cnt_r, fail_cnt_s, fail_inc_s;
    logic                car_q_r, car_rise_s;
    logic                to_load_s, to_en_s, to_done_s;
    logic                hold_load_s, hold_en_s, hold_done_s;
    logic [HD_W-1:0]     hold_val_s;
    logic [DIGIT_W-1:0]  slice_s [CODE_LEN];
    logic [DIGIT_W-1:0]  expected_s;
    logic                pass_ok_r, pass_fail_r, locked_r, busy_r;

    assign car_rise_s = bus.car_in & ~car_q_r;
    assign fail_inc_s = fail_cnt_r + FAIL_W'(1);

    // Split code_word into digits; slice 0 is the most significant digit.
    always_comb begin
        for (int i = 0; i < CODE_LEN; i++) begin
            slice_s[i] = bus.code_word[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
        end
        expected_s = slice_s[idx_r];
    end

    // Inter-digit timeout: reloaded on arm and on every accepted digit.
    passcode_timer #(.MAX_VAL(TIMEOUT_CYCLES)) u_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (to_load_s),
        .load_val (TO_W'(TIMEOUT_CYCLES - 1)),
        .en       (to_en_s),
        .done     (to_done_s)
    );

    // Shared duration timer for the PASS hold and the lockout period.
    passcode_timer #(.MAX_VAL(HOLD_MAX)) u_hold (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (hold_load_s),
        .load_val (hold_val_s),
        .en       (hold_en_s),
        .done     (hold_done_s)
    );

    // Next-state, datapath updates and timer controls.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        mismatch_s  = mismatch_r;
        fail_cnt_s  = fail_cnt_r;
        to_load_s   = 1'b0;
        to_en_s     = 1'b0;
        hold_load_s = 1'b0;
        hold_en_s   = 1'b0;
        hold_val_s  = HD_W'(PASS_HOLD - 1);
        case (state_r)
            IDLE: begin
                if (car_rise_s) begin
                    state_s    = COLLECT;
                    idx_s      = {IDX_W{1'b0}};
                    mismatch_s = 1'b0;
                    to_load_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            COLLECT: begin
                if (!bus.car_in) begin
                    state_s = IDLE;
                end else if (bus.digit_valid) begin
                    // Sticky mismatch: keep collecting to the full length.
                    if (bus.digit != expected_s) begin
                        mismatch_s = 1'b1;
                    end else begin
                        mismatch_s = mismatch_r;
                    end
                    to_load_s = 1'b1;
                    if (idx_r == IDX_W'(CODE_LEN - 1)) begin
                        state_s = CHECK;
                        idx_s   = {IDX_W{1'b0}};
                    end else begin
                        idx_s   = idx_r + IDX_W'(1);
                    end
                end else if (to_done_s) begin
                    state_s = FAIL;
                end else begin
                    to_en_s = 1'b1;
                end
            end
            CHECK: begin
                if (mismatch_r) begin
                    state_s = FAIL;
                end else begin
                    state_s     = PASS;
                    hold_load_s = 1'b1;
                    hold_val_s  = HD_W'(PASS_HOLD - 1);
                end
            end
            PASS: begin
                fail_cnt_s = {FAIL_W{1'b0}};
                if (hold_done_s) begin
                    state_s = IDLE;
                end else begin
                    hold_en_s = 1'b1;
                end
            end
            FAIL: begin
                if (fail_inc_s == FAIL_W'(MAX_FAIL)) begin
                    state_s     = LOCKOUT;
                    fail_cnt_s  = fail_inc_s;
                    hold_load_s = 1'b1;
                    hold_val_s  = HD_W'(LOCK_CYCLES - 1);
                end else if (bus.car_in) begin
                    state_s    = COLLECT;
                    fail_cnt_s = fail_inc_s;
                    idx_s      = {IDX_W{1'b0}};
                    mismatch_s = 1'b0;
                    to_load_s  = 1'b1;
                end else begin
                    state_s    = IDLE;
                    fail_cnt_s = fail_inc_s;
                end
            end
            LOCKOUT: begin
                if (hold_done_s) begin
                    state_s    = IDLE;
                    fail_cnt_s = {FAIL_W{1'b0}};
                end else begin
                    hold_en_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; outputs decode the next state so
    // they change on the same edge as the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            idx_r       <= {IDX_W{1'b0}};
            mismatch_r  <= 1'b0;
            fail_cnt_r  <= {FAIL_W{1'b0}};
            car_q_r     <= 1'b0;
            pass_ok_r   <= 1'b0;
            pass_fail_r <= 1'b0;
            locked_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            mismatch_r  <= mismatch_s;
            fail_cnt_r  <= fail_cnt_s;
            car_q_r     <= bus.car_in;
            pass_ok_r   <= (state_s == PASS);
            pass_fail_r <= (state_s == FAIL);
            locked_r    <= (state_s == LOCKOUT);
            busy_r      <= (state_s == COLLECT) || (state_s == CHECK);
        end
    end

    assign bus.pass_ok   = pass_ok_r;
    assign bus.pass_fail = pass_fail_r;
    assign bus.locked    = locked_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_passcode_checker.sv
// Directed bench for passcode_checker. Outputs are observed 1 ns after each
// rising edge as {pass_ok, pass_fail, locked, busy}.
module tb_passcode_checker;
    import passcode_pkg::*;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    int   lock_seen;
    logic any_pass;

    passcode_checker_if #(.CODE_LEN(4), .DIGIT_W(4)) bus ();

    passcode_checker dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, bus.pass_ok, bus.pass_fail, bus.locked, bus.busy}, {28'd0, exp});
    endtask

    task automatic dig(input logic [3:0] d);
        bus.digit       = d;
        bus.digit_valid = 1'b1;
        tick();
        bus.digit_valid = 1'b0;
    endtask

    // Four digits; state is CHECK after the last one.
    task automatic enter4(input string tag, input logic [15:0] code);
        dig(code[15:12]); chk_out({tag, "_d1"}, 4'b0001);
        dig(code[11:8]);  chk_out({tag, "_d2"}, 4'b0001);
        dig(code[7:4]);   chk_out({tag, "_d3"}, 4'b0001);
        dig(code[3:0]);   chk_out({tag, "_d4"}, 4'b0001);
    endtask

    task automatic arm();
        bus.car_in = 1'b0; tick();
        bus.car_in = 1'b1; tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n         = 1'b0;
        bus.car_in      = 1'b0;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'h0;
        bus.code_word   = 16'h1234;
        #12;
        chk_out("reset", 4'b0000);
        reset_n = 1'b1;
        tick();
        chk_out("idle", 4'b0000);

        // 1: correct entry
        bus.car_in = 1'b1; tick();
        chk_out("t1_arm", 4'b0001);
        enter4("t1", 16'h1234);
        tick(); chk_out("t1_pass_a", 4'b1000);
        tick(); chk_out("t1_pass_b", 4'b1000);
        tick(); chk_out("t1_idle", 4'b0000);

        // 2: wrong then right with car held; then two fails do not lock
        arm(); chk_out("t2_arm", 4'b0001);
        enter4("t2w", 16'h1294);
        tick(); chk_out("t2_fail", 4'b0100);
        tick(); chk_out("t2_retry", 4'b0001);
        enter4("t2r", 16'h1234);
        tick(); chk_out("t2_pass_a", 4'b1000);
        tick(); chk_out("t2_pass_b", 4'b1000);
        tick(); chk_out("t2_idle", 4'b0000);
        arm();
        enter4("t2x", 16'h5555);
        tick(); chk_out("t2_fail1", 4'b0100);
        tick(); chk_out("t2_retry1", 4'b0001);
        enter4("t2y", 16'h5555);
        tick(); chk_out("t2_fail2", 4'b0100);
        tick(); chk_out("t2_nolock", 4'b0001);
        enter4("t2z", 16'h1234);
        tick(); chk_out("t2_pass_c", 4'b1000);
        tick(); tick(); chk_out("t2_idle2", 4'b0000);

        // 3: three fails lock out for 100 cycles
        arm();
        enter4("t3a", 16'h0000);
        tick(); chk_out("t3_fail1", 4'b0100);
        tick();
        enter4("t3b", 16'h1243);
        tick(); chk_out("t3_fail2", 4'b0100);
        tick();
        enter4("t3c", 16'h4321);
        tick(); chk_out("t3_fail3", 4'b0100);
        tick(); chk_out("t3_locked", 4'b0010);
        lock_seen = 1;
        any_pass  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dig(4'(i + 1));
            if (bus.locked) lock_seen++;
            if (bus.pass_ok) any_pass = 1'b1;
        end
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.pass_ok) any_pass = 1'b1;
            if (bus.locked) lock_seen++;
            else break;
        end
        chk("t3_lock_len", lock_seen, 100);
        chk("t3_no_pass", {31'd0, any_pass}, 0);
        chk_out("t3_after", 4'b0000);
        dig(4'h1); chk_out("t3_idle_dig", 4'b0000);
        tick(); chk_out("t3_still_idle", 4'b0000);
        arm(); chk_out("t3_rearm", 4'b0001);

        // 4: timeout after one digit
        dig(4'h1); chk_out("t4_d1", 4'b0001);
        for (int i = 0; i < 49; i++) tick();
        chk_out("t4_before_to", 4'b0001);
        tick(); chk_out("t4_timeout", 4'b0100);
        tick(); chk_out("t4_retry", 4'b0001);
        enter4("t4", 16'h1234);
        tick(); chk_out("t4_pass", 4'b1000);
        tick(); tick(); chk_out("t4_idle", 4'b0000);

        // 5: async reset mid-entry
        arm();
        dig(4'h1); dig(4'h2);
        chk_out("t5_busy", 4'b0001);
        #2 reset_n = 1'b0;
        #1 chk_out("t5_async", 4'b0000);
        bus.car_in = 1'b0;
        tick();
        reset_n = 1'b1;
        tick(); chk_out("t5_idle", 4'b0000);
        dig(4'h3); dig(4'h4);
        chk_out("t5_ignored", 4'b0000);
        bus.car_in = 1'b1; tick();
        chk_out("t5_arm", 4'b0001);

        // 6: car leaves mid-entry; fresh arrival with digit on arm edge
        enter4("t6p", 16'h1234);
        tick(); tick(); tick();
        arm();
        dig(4'h1); dig(4'h2); dig(4'h3);
        chk_out("t6_three", 4'b0001);
        bus.car_in = 1'b0; tick();
        chk_out("t6_abort", 4'b0000);
        tick(); chk_out("t6_quiet", 4'b0000);
        bus.car_in = 1'b1; dig(4'h7);
        chk_out("t6_arm", 4'b0001);
        enter4("t6", 16'h1234);
        tick(); chk_out("t6_pass", 4'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
